// File: rtl/jt053247_pkg.sv
// Shared types and constants for the sprite line-drawing engine.
// One source pixel spans 2^FRAC_W accumulator units; a tile row is 16 source pixels.
package jt053247_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH0,
    FETCH1,
    DRAW
  } state_t;

  localparam logic [9:0]  ZOOM_UNITY = 10'h40;
  localparam int          FRAC_W     = 6;
  localparam logic [15:0] ACC_END    = {2'b00, ZOOM_UNITY, 4'b0000};

  // idx 0 is the leftmost pixel, held in the top nibble
  function automatic logic [3:0] pix_nibble(input logic [63:0] pix, input logic [3:0] idx);
    logic [63:0] sh;
    sh = pix << {idx, 2'b00};
    return sh[63:60];
  endfunction

endpackage

// File: rtl/jt053247_zacc.sv
// Horizontal zoom accumulator: integer part selects the source pixel, fraction
// may carry over between chunks of one wide sprite.
module jt053247_zacc
  import jt053247_pkg::*;
(
  input  logic       rst,
  input  logic       clk,
  input  logic       load_i,
  input  logic       keep_i,
  input  logic       step_i,
  input  logic [9:0] zoom_i,
  output logic [3:0] src_o,
  output logic       end_o
);

  logic [15:0] acc_q, acc_d, acc_nx;
  logic [9:0]  step;

  // a zero step would never leave the row
  assign step   = (zoom_i == 10'd0) ? 10'd1 : zoom_i;
  assign acc_nx = acc_q + {6'd0, step};
  assign end_o  = (acc_nx >= ACC_END);
  assign src_o  = acc_q[FRAC_W+3:FRAC_W];

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = {10'd0, keep_i ? acc_q[FRAC_W-1:0] : 6'd0};
    end else if (step_i) begin
      acc_d = acc_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/jt053247_draw.sv
// Sprite row drawer: fetches one 16-pixel tile row as two ROM words and writes the
// zoomed, non-transparent pixels into the line buffer, one output pixel per clock.
module jt053247_draw
  import jt053247_pkg::*;
#(
  parameter int AW    = 9,
  parameter int MAXPX = 256
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          dr_start,
  output logic          dr_busy,
  input  logic [15:0]   code,
  input  logic [9:0]    attr,
  input  logic          hflip,
  input  logic          vflip,
  input  logic [3:0]    ysub,
  input  logic [8:0]    hpos,
  input  logic [11:0]   hzoom,
  input  logic          hz_keep,
  output logic [20:0]   rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [31:0]   rom_data,
  output logic [AW-1:0] buf_addr,
  output logic          buf_we,
  output logic [13:0]   buf_din
);

  localparam logic [AW-1:0] NLAST = AW'(MAXPX - 1);

  state_t        state_q, state_d;
  logic          held_q, held_d;
  logic [15:0]   code_q;
  logic [3:0]    row_q;
  logic [9:0]    attr_q;
  logic          hflip_q;
  logic [AW-1:0] hpos_q;
  logic [9:0]    zoom_q;
  logic [63:0]   pix_q;
  logic [AW-1:0] n_q;
  logic          load, step, take, zend;
  logic [3:0]    src, s_eff, pen;
  logic          unused_hz;

  assign unused_hz = ^hzoom[11:10];

  jt053247_zacc u_zacc (
    .rst    (rst),
    .clk    (clk),
    .load_i (load),
    .keep_i (hz_keep),
    .step_i (step),
    .zoom_i (zoom_q),
    .src_o  (src),
    .end_o  (zend)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: if (dr_start) begin
        load    = 1'b1;
        state_d = FETCH0;
      end
      FETCH0: if (held_q && rom_ok) begin
        take    = 1'b1;
        state_d = FETCH1;
      end
      FETCH1: if (held_q && rom_ok) begin
        take    = 1'b1;
        state_d = DRAW;
      end
      DRAW: begin
        step = 1'b1;
        if (zend || n_q == NLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rom_ok is only trusted once the current address has been presented for a cycle
  assign held_d = (state_q == FETCH0 || state_q == FETCH1) && !take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= 1'b0;
      code_q  <= '0;
      row_q   <= '0;
      attr_q  <= '0;
      hflip_q <= 1'b0;
      hpos_q  <= '0;
      zoom_q  <= '0;
      pix_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      if (load) begin
        code_q  <= code;
        row_q   <= ysub ^ {4{vflip}};
        attr_q  <= attr;
        hflip_q <= hflip;
        hpos_q  <= AW'(hpos);
        zoom_q  <= hzoom[9:0];
        n_q     <= '0;
      end
      if (take && state_q == FETCH0) pix_q[63:32] <= rom_data;
      if (take && state_q == FETCH1) pix_q[31:0]  <= rom_data;
      if (step) n_q <= n_q + AW'(1);
    end
  end

  assign s_eff    = hflip_q ? ~src : src;
  assign pen      = pix_nibble(pix_q, s_eff);
  assign dr_busy  = (state_q != IDLE);
  assign rom_cs   = (state_q == FETCH0) || (state_q == FETCH1);
  assign rom_addr = {code_q, row_q, state_q == FETCH1};
  assign buf_we   = (state_q == DRAW) && (pen != 4'd0);
  assign buf_addr = hpos_q + n_q;
  assign buf_din  = {attr_q, pen};

endmodule

// File: tb/tb_jt053247_draw.sv
// Directed bench for jt053247_draw: table of tile rows with hand-computed results,
// a behavioural ROM with wait states and a stale rom_ok pulse, plus reset/busy sequences.
module tb_jt053247_draw;

  localparam logic [31:0] W0   = 32'h12345678;
  localparam logic [31:0] W1   = 32'h9ABCDEF0;
  localparam logic [9:0]  ATTR = 10'h2A5;

  logic        rst, clk;
  logic        dr_start, dr_busy;
  logic [15:0] code;
  logic [9:0]  attr;
  logic        hflip, vflip, hz_keep;
  logic [3:0]  ysub;
  logic [8:0]  hpos;
  logic [11:0] hzoom;
  logic [20:0] rom_addr;
  logic        rom_cs, rom_ok;
  logic [31:0] rom_data;
  logic [8:0]  buf_addr;
  logic        buf_we;
  logic [13:0] buf_din;

  int checks = 0;
  int failures = 0;

  logic [20:0] rom_log[$];
  logic [22:0] wr_log[$];
  logic [22:0] exp_log[$];
  int          model_frac = 0;

  jt053247_draw #(.AW(9), .MAXPX(256)) dut (
    .rst(rst), .clk(clk), .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .hflip(hflip), .vflip(vflip), .ysub(ysub),
    .hpos(hpos), .hzoom(hzoom), .hz_keep(hz_keep),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_din(buf_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: data valid 3 cycles after an address settles; a garbage rom_ok pulse when cs rises
  int          rom_wait = 0;
  logic        prev_cs = 1'b0;
  logic [20:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rom_cs && prev_cs && rom_addr == prev_addr) rom_wait = rom_wait + 1;
    else rom_wait = 0;
    if (rom_cs && (!prev_cs || rom_addr != prev_addr)) rom_log.push_back(rom_addr);
    rom_ok   = (rom_cs && rom_wait >= 3) || (rom_cs && !prev_cs);
    rom_data = (rom_cs && rom_wait >= 3) ? (rom_addr[0] ? W1 : W0) : 32'hDEADBEEF;
    prev_cs   = rom_cs;
    prev_addr = rom_addr;
  end

  always @(negedge clk) if (buf_we) wr_log.push_back({buf_addr, buf_din});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic hf, input logic vf, input logic keep,
                            input logic [8:0] hp, input logic [11:0] z);
    code = 16'h1234; attr = ATTR; ysub = 4'd5;
    hflip = hf; vflip = vf; hz_keep = keep; hpos = hp; hzoom = z;
  endtask

  task automatic build_model(input logic hf, input logic keep, input logic [8:0] hp, input logic [11:0] z);
    int acc, n, stp, s;
    logic [3:0]  pen;
    logic [63:0] pix;
    pix = {W0, W1};
    exp_log.delete();
    stp = (z[9:0] == 10'd0) ? 1 : int'(z[9:0]);
    acc = keep ? model_frac : 0;
    n = 0;
    do begin
      s = acc / 64;
      if (hf) s = 15 - s;
      pen = pix[63-4*s -: 4];
      if (pen != 4'd0) exp_log.push_back({9'(int'(hp) + n), ATTR, pen});
      acc = acc + stp;
      n++;
    end while (acc < 1024 && n < 256);
    model_frac = acc % 64;
  endtask

  // issues dr_start when idle, returns the cycle of the first write (0 = none)
  task automatic run_tile(input logic hf, input logic vf, input logic keep, input logic [8:0] hp,
                          input logic [11:0] z, input logic poke, output int first_we);
    int t;
    t = 0;
    while (dr_busy && t < 3000) begin @(negedge clk); t++; end
    rom_log.delete();
    wr_log.delete();
    set_inputs(hf, vf, keep, hp, z);
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    check("busy_after_start", dr_busy, 1);
    first_we = 0;
    t = 1;
    while (t < 3000) begin
      if (buf_we && first_we == 0) first_we = t;
      if (!dr_busy) break;
      dr_start = poke && (t == 2 || t == 10);
      @(negedge clk);
      t++;
    end
    dr_start = 1'b0;
    check("tile_finished", t < 3000, 1);
  endtask

  typedef struct {
    logic        hf, vf, keep;
    logic [8:0]  hp;
    logic [11:0] z;
    logic [20:0] rom0, rom1;
    int          nwr;
    logic [8:0]  a_first;
    logic [3:0]  p_first, p_second;
    logic [8:0]  a_last;
    logic [3:0]  p_last;
  } vec_t;

  vec_t vt[9];

  initial begin
    int first_we, mism, t;
    vt[0] = '{1'b0, 1'b0, 1'b0, 9'h100, 12'h040, 21'h2468A, 21'h2468B, 15,  9'h100, 4'h1, 4'h2, 9'h10E, 4'hF};
    vt[1] = '{1'b1, 1'b1, 1'b0, 9'h100, 12'h040, 21'h24694, 21'h24695, 15,  9'h101, 4'hF, 4'hE, 9'h10F, 4'h1};
    vt[2] = '{1'b0, 1'b0, 1'b0, 9'h100, 12'hC80, 21'h2468A, 21'h2468B, 8,   9'h100, 4'h1, 4'h3, 9'h107, 4'hF};
    vt[3] = '{1'b0, 1'b0, 1'b0, 9'h100, 12'h020, 21'h2468A, 21'h2468B, 30,  9'h100, 4'h1, 4'h1, 9'h11D, 4'hF};
    vt[4] = '{1'b0, 1'b0, 1'b0, 9'h000, 12'h030, 21'h2468A, 21'h2468B, 20,  9'h000, 4'h1, 4'h1, 9'h013, 4'hF};
    vt[5] = '{1'b0, 1'b0, 1'b1, 9'h000, 12'h030, 21'h2468A, 21'h2468B, 20,  9'h000, 4'h1, 4'h2, 9'h013, 4'hF};
    vt[6] = '{1'b0, 1'b0, 1'b0, 9'h000, 12'h030, 21'h2468A, 21'h2468B, 20,  9'h000, 4'h1, 4'h1, 9'h013, 4'hF};
    vt[7] = '{1'b0, 1'b0, 1'b0, 9'h1FC, 12'h040, 21'h2468A, 21'h2468B, 15,  9'h1FC, 4'h1, 4'h2, 9'h00A, 4'hF};
    vt[8] = '{1'b0, 1'b0, 1'b0, 9'h000, 12'h000, 21'h2468A, 21'h2468B, 256, 9'h000, 4'h1, 4'h1, 9'h0FF, 4'h4};

    rst = 1'b1; dr_start = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 9'h000, 12'h040);
    repeat (3) @(negedge clk);
    check("rst_busy", dr_busy, 0);
    check("rst_rom_cs", rom_cs, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_din", buf_din, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      build_model(vt[i].hf, vt[i].keep, vt[i].hp, vt[i].z);
      run_tile(vt[i].hf, vt[i].vf, vt[i].keep, vt[i].hp, vt[i].z, i == 0, first_we);
      if (i == 0) check("v0_first_write_cycle", first_we, 9);
      check($sformatf("v%0d_rom_requests", i), rom_log.size(), 2);
      if (rom_log.size() == 2) begin
        check($sformatf("v%0d_rom_addr0", i), rom_log[0], vt[i].rom0);
        check($sformatf("v%0d_rom_addr1", i), rom_log[1], vt[i].rom1);
      end
      check($sformatf("v%0d_write_count", i), wr_log.size(), vt[i].nwr);
      if (wr_log.size() >= 2) begin
        check($sformatf("v%0d_first_write", i), wr_log[0], {vt[i].a_first, ATTR, vt[i].p_first});
        check($sformatf("v%0d_second_pen", i), wr_log[1][3:0], vt[i].p_second);
        check($sformatf("v%0d_last_write", i), wr_log[wr_log.size()-1], {vt[i].a_last, ATTR, vt[i].p_last});
      end
      mism = (wr_log.size() > exp_log.size()) ? wr_log.size() - exp_log.size() : exp_log.size() - wr_log.size();
      for (int j = 0; j < wr_log.size() && j < exp_log.size(); j++)
        if (wr_log[j] !== exp_log[j]) mism++;
      check($sformatf("v%0d_pixel_mismatches", i), mism, 0);
    end

    // reset while the second word is outstanding
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 1'b0, 9'h100, 12'h040);
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    t = 0;
    while (!(rom_cs && rom_addr[0]) && t < 100) begin @(negedge clk); t++; end
    check("reach_fetch1", t < 100, 1);
    rst = 1'b1;
    #1;
    check("abort_rom_cs", rom_cs, 0);
    check("abort_busy", dr_busy, 0);
    check("abort_buf_we", buf_we, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_frac = 0;
    build_model(1'b0, 1'b0, 9'h100, 12'h040);
    run_tile(1'b0, 1'b0, 1'b0, 9'h100, 12'h040, 1'b0, first_we);
    check("after_abort_rom_requests", rom_log.size(), 2);
    check("after_abort_write_count", wr_log.size(), 15);
    if (wr_log.size() == 15) check("after_abort_last_write", wr_log[14], {9'h10E, ATTR, 4'hF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
